hash_mem_arbiter: RTL and testbench
===================================

# hash_mem_arbiter

Round-robin arbiter that lets N SHA-256/bitcoin hash cores share the single-port message/output memory. Each core issues word-wide read and write beats on its own request port. The arbiter serializes the beats onto one registered memory port and routes read data back with fixed latency. A lock mechanism lets a core keep the port for an uninterrupted burst, such as a 16-word message-block fetch or a run of 16 nonce result writes.

## Interface
- N_REQ, 4: number of requesting cores (2..8)
- AW, 16: memory address width
- DW, 32: memory data width
- MAX_LOCK, 32: maximum beats one owner may hold a lock before forced release (1..255)

- clk  in  1  system clock; also drives mem_clk
- reset  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-core beat request
- req_we  in  N_REQ  per-core beat type (1 = write)
- req_lock  in  N_REQ  per-core "keep port after this beat"
- req_addr  in  N_REQ*AW  packed addresses; core i at [i*AW +: AW]
- req_wdata  in  N_REQ*DW  packed write data; core i at [i*DW +: DW]
- req_ready  out  N_REQ  one-hot grant, combinational; beat accepted when req_valid[i] & req_ready[i]
- rsp_valid  out  N_REQ  read data valid for core i
- rsp_data  out  DW  read data, shared by all cores
- owner  out  $clog2(N_REQ)  index of current lock owner; meaningful only in state OWN
- busy  out  1  high in state OWN
- mem_clk  out  1  equals clk
- mem_we  out  1  registered write strobe
- mem_addr  out  AW  registered address
- mem_write_data  out  DW  registered write data
- mem_read_data  in  DW  memory read data

## Operation
- **Reset values.**
  - Outputs: mem_we=0, mem_addr=0, mem_write_data=0, rsp_valid=0, busy=0, owner=0.
  - Internal: rr_ptr=0, lock_cnt=0, state=IDLE.
  - req_ready is forced to 0 while reset is high.
- **State IDLE.**
  - Grant goes to the first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, … modulo N_REQ.
  - At most one req_ready bit is set. If no request is present, req_ready=0.
- **Accepted beat from core g** (applies in any state):
  - mem_addr and mem_we load from core g's request.
  - mem_write_data loads only on writes and holds its value otherwise.
  - mem_we is a single-cycle pulse; it returns to 0 on the next edge unless another write beat is accepted.
- **IDLE -> OWN.** Taken when an accepted beat has req_lock[g]=1. Sets owner=g and lock_cnt=1.
- **IDLE, accepted beat with req_lock[g]=0.** Stays in IDLE. rr_ptr becomes (g+1) mod N_REQ.
- **State OWN.**
  - Only the owner is eligible: req_ready = req_valid[owner] at bit owner; all other bits are 0.
  - Each accepted beat increments lock_cnt.
- **OWN -> IDLE.**
  - Taken when an accepted beat has req_lock=0, or when that beat brings lock_cnt to MAX_LOCK (forced release).
  - On exit, rr_ptr becomes (owner+1) mod N_REQ and lock_cnt clears.
- **Owner idle in OWN.** If the owner drops req_valid while in OWN, the port idles. Idle cycles do not count toward MAX_LOCK.
- **Read return path.**
  - A 2-deep pipeline tracks the target core ID of each read beat. Write beats produce no response.
  - rsp_data = mem_read_data, passed through combinationally.
  - rsp_valid is one-hot or zero.
- **Back-to-back beats.** One beat per cycle is sustained, including read/write interleaving and owner changes on consecutive cycles.
- **Hazard ordering.** A write followed by a read to the same address returns the newly written data, because the memory processes beats in order. The arbiter does no forwarding.
- **Reset mid-operation.**
  - Beats still in flight are dropped: no rsp_valid after reset.
  - The lock is released and rr_ptr returns to 0.

## Timing
- **Read latency.**
  - Beat accepted at edge E0; mem_addr is valid after E0.
  - The memory samples at E1.
  - rsp_valid[g]=1 and rsp_data is valid in the cycle between E1 and E2 (sampled by the core at E2).
- **Write timing.** A write accepted at E0 drives mem_we=1 during cycle E0..E1 and is committed at E1.
- **Grant is combinational.** req_ready depends on req_valid, state, owner and rr_ptr only; it never depends on req_addr or req_wdata.
- **Arbitration fairness.** When every core has an unlocked request pending, each core waits at most N_REQ-1 cycles.
- **Lock fairness.** With locks, a core waits at most (N_REQ-1)*MAX_LOCK accepted beats plus owner idle cycles.

## Test plan
- **Reset:** hold reset 3 cycles with all req_valid=1 -> req_ready=0, mem_we=0, mem_addr=0, rsp_valid=0; the first grant after release goes to core 0.
- **Round-robin:** all 4 cores request continuous unlocked reads of addresses 10+i -> grant order 0,1,2,3,0; core i receives mem[10+i] with rsp_valid 2 edges after acceptance.
- **Locked burst:** core 2 reads addresses 0..15 with req_lock=1 on beats 0..14 and 0 on beat 15, while cores 0/1 request throughout -> 16 consecutive grants to core 2, busy=1, owner=2; the next grant goes to core 3 if requesting, else core 0.
- **Forced release:** MAX_LOCK=4, core 1 holds req_lock=1 continuously while core 0 requests -> exactly 4 core-1 beats, then a grant to core 0.
- **Write-then-read:** core 3 writes 32'hDEADBEEF to address 0x20 on one cycle and reads 0x20 on the next -> mem_we pulses 1 cycle, and rsp_data=32'hDEADBEEF with rsp_valid[3].
- **Reset mid-burst:** assert reset one cycle after core 1 issues a locked read -> no rsp_valid, busy=0 after reset, and the lock is cleared.

Source files
------------

// File: rtl/hash_mem_arbiter.sv
// hash_mem_arbiter
//   Round-robin arbiter that lets N_REQ hash cores share one single-port
//   message/output memory. Beats are serialized onto a registered memory
//   port. Read data is routed back two edges after acceptance. A core can
//   lock the port for an uninterrupted burst. The lock is released by the
//   core or forced after MAX_LOCK beats.
//
//   Ports
//     clk, reset        system clock, synchronous active-high reset
//     req_valid/we/lock per-core beat request, type (1=write), keep-port flag
//     req_addr/wdata    packed per-core address / write data (core i at i*W)
//     req_ready         one-hot combinational grant
//     rsp_valid         one-hot read-data valid, rsp_data shared by all cores
//     owner, busy       current lock owner, high while a lock is held
//     mem_*             registered single-port memory interface, mem_clk = clk
module hash_mem_arbiter #(
    parameter int N_REQ    = 4,
    parameter int AW       = 16,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ-1:0]          req_lock,
    input  logic [N_REQ*AW-1:0]       req_addr,
    input  logic [N_REQ*DW-1:0]       req_wdata,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DW-1:0]             rsp_data,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic                      busy,
    output logic                      mem_clk,
    output logic                      mem_we,
    output logic [AW-1:0]             mem_addr,
    output logic [DW-1:0]             mem_write_data,
    input  logic [DW-1:0]             mem_read_data
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_LOCK + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [CW-1:0]   cnt_inc;

    logic            grant_vld;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   cand;
    logic [N_REQ-1:0] ready_c;

    logic            sel_we;
    logic            sel_lock;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    logic            vld_p0, vld_p1;
    logic [IW-1:0]   id_p0, id_p1;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (v == IW'(N_REQ - 1)) ? '0 : v + 1'b1;
    endfunction

    // Grant: the owner alone while locked, otherwise first requester from rr_ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (state_q == OWN) begin
            grant_vld = req_valid[owner_q];
            grant_idx = owner_q;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = IW'((int'(rr_ptr_q) + k) % N_REQ);
                if (!grant_vld && req_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (reset) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin
        ready_c = '0;
        if (grant_vld) begin
            ready_c[grant_idx] = 1'b1;
        end
    end

    assign req_ready = ready_c;

    // Fields of the granted beat.
    always_comb begin
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_we    = req_we[i];
                sel_lock  = req_lock[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    assign cnt_inc = lock_cnt_q + 1'b1;

    // Lock FSM. With MAX_LOCK == 1 a locked beat is already the last one,
    // so it is treated like an unlocked beat.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        if (grant_vld) begin
            case (state_q)
                IDLE: begin
                    if (sel_lock && (MAX_LOCK > 1)) begin
                        state_d    = OWN;
                        owner_d    = grant_idx;
                        lock_cnt_d = CW'(1);
                    end else begin
                        rr_ptr_d = wrap_inc(grant_idx);
                    end
                end
                OWN: begin
                    if (!sel_lock || (cnt_inc == CW'(MAX_LOCK))) begin
                        state_d    = IDLE;
                        rr_ptr_d   = wrap_inc(owner_q);
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = cnt_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Stage p0: memory port registers, read tag enters the return pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            vld_p0         <= 1'b0;
            id_p0          <= '0;
        end else begin
            mem_we <= grant_vld & sel_we;
            vld_p0 <= grant_vld & ~sel_we;
            if (grant_vld) begin
                mem_addr <= sel_addr;
                id_p0    <= grant_idx;
            end
            if (grant_vld && sel_we) begin
                mem_write_data <= sel_wdata;
            end
        end
    end

    // Stage p1: memory has sampled the address, its read data is on the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            id_p1  <= '0;
        end else begin
            vld_p1 <= vld_p0;
            id_p1  <= id_p0;
        end
    end

    assign rsp_valid = vld_p1 ? (N_REQ'(1) << id_p1) : '0;
    assign rsp_data  = mem_read_data;
    assign owner     = owner_q;
    assign busy      = (state_q == OWN);
    assign mem_clk   = clk;

endmodule

// File: tb/tb_hash_mem_arbiter.sv
// Testbench for hash_mem_arbiter: directed scenarios plus randomized traffic,
// checked against a cycle-level transaction model of the arbitration rules.
module tb_hash_mem_arbiter;
    localparam int N    = 4;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int MAXL = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [N-1:0]      req_valid, req_we, req_lock;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_ready, rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [1:0]        owner;
    logic              busy, mem_clk, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_write_data, mem_read_data;

    logic [N-1:0]      b_req_valid, b_req_we, b_req_lock;
    logic [N*AW-1:0]   b_req_addr;
    logic [N*DW-1:0]   b_req_wdata;
    logic [N-1:0]      b_req_ready, b_rsp_valid;
    logic [DW-1:0]     b_rsp_data;
    logic [1:0]        b_owner;
    logic              b_busy, b_mem_clk, b_mem_we;
    logic [AW-1:0]     b_mem_addr;
    logic [DW-1:0]     b_mem_write_data;

    hash_mem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .MAX_LOCK(MAXL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .owner(owner), .busy(busy),
        .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    hash_mem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .MAX_LOCK(4)) dut_ml4 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_we(b_req_we), .req_lock(b_req_lock),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_ready(b_req_ready),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .owner(b_owner), .busy(b_busy),
        .mem_clk(b_mem_clk), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_write_data(b_mem_write_data), .mem_read_data(32'h0)
    );

    // Initial memory contents for locations never written.
    function automatic logic [31:0] pat(input logic [15:0] a);
        return {a, ~a} ^ 32'h5A5A_3C3C;
    endfunction

    // Synchronous single-port memory attached to the main instance.
    logic [31:0] mem [0:65535];
    bit          mem_written [0:65535];
    logic [31:0] rd_q;
    always @(posedge mem_clk) begin
        if (mem_we) begin
            mem[mem_addr]         <= mem_write_data;
            mem_written[mem_addr] <= 1'b1;
        end
        rd_q <= mem_written[mem_addr] ? mem[mem_addr] : pat(mem_addr);
    end
    assign mem_read_data = rd_q;

    // Reference model state (transaction level).
    int          n_vec, n_err;
    bit          chk_en;
    int          cyc;
    int          m_rr, m_owner, m_cnt;
    bit          m_own;
    logic        m_we;
    logic [15:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_mem [0:65535];
    bit          m_written [0:65535];
    int          exp_core [8];
    logic [31:0] exp_data [8];

    function automatic int model_grant(input logic [N-1:0] v);
        if (reset) return -1;
        if (m_own) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (v[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_loop();
        int g;
        logic [15:0] a;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_rr = 0; m_own = 0; m_cnt = 0; m_owner = 0;
                m_we = 1'b0; m_addr = '0; m_wdata = '0;
                exp_core[(cyc + 1) % 8] = -1;
                exp_core[(cyc + 2) % 8] = -1;
            end else begin
                g = model_grant(req_valid);
                m_we = 1'b0;
                if (g >= 0) begin
                    a = req_addr[g*AW +: AW];
                    m_addr = a;
                    if (req_we[g]) begin
                        m_we = 1'b1;
                        m_wdata = req_wdata[g*DW +: DW];
                        m_mem[a] = m_wdata;
                        m_written[a] = 1'b1;
                    end else begin
                        exp_core[(cyc + 2) % 8] = g;
                        exp_data[(cyc + 2) % 8] = m_written[a] ? m_mem[a] : pat(a);
                    end
                    if (!m_own) begin
                        if (req_lock[g]) begin
                            m_own = 1; m_owner = g; m_cnt = 1;
                        end else begin
                            m_rr = (g + 1) % N;
                        end
                    end else begin
                        m_cnt++;
                        if (!req_lock[g] || m_cnt == MAXL) begin
                            m_own = 0; m_rr = (m_owner + 1) % N; m_cnt = 0;
                        end
                    end
                end
            end
            exp_core[cyc % 8] = -1;
            cyc++;
        end
    endtask

    task automatic scoreboard_loop();
        int g, e;
        logic [3:0] er;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                g = model_grant(req_valid);
                er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
                n_vec++;
                if (req_ready !== er) begin
                    n_err++;
                    $display("FAIL sb_ready cyc=%0d got=%b exp=%b", cyc, req_ready, er);
                end
                n_vec++;
                if (busy !== m_own) begin
                    n_err++;
                    $display("FAIL sb_busy cyc=%0d got=%b exp=%b", cyc, busy, m_own);
                end
                if (m_own) begin
                    n_vec++;
                    if (owner !== 2'(m_owner)) begin
                        n_err++;
                        $display("FAIL sb_owner cyc=%0d got=%0d exp=%0d", cyc, owner, m_owner);
                    end
                end
                n_vec++;
                if (mem_we !== m_we || mem_addr !== m_addr || mem_write_data !== m_wdata) begin
                    n_err++;
                    $display("FAIL sb_memport cyc=%0d got we=%b a=%h d=%h exp we=%b a=%h d=%h",
                             cyc, mem_we, mem_addr, mem_write_data, m_we, m_addr, m_wdata);
                end
                e = exp_core[cyc % 8];
                er = (e >= 0) ? (4'b0001 << e) : 4'b0000;
                n_vec++;
                if (rsp_valid !== er) begin
                    n_err++;
                    $display("FAIL sb_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, er);
                end
                if (e >= 0) begin
                    n_vec++;
                    if (rsp_data !== exp_data[cyc % 8]) begin
                        n_err++;
                        $display("FAIL sb_rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data, exp_data[cyc % 8]);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        req_valid = '0; req_we = '0; req_lock = '0;
    endtask

    task automatic set_core(input int i, input logic v, input logic we, input logic lk,
                            input logic [15:0] a, input logic [31:0] d);
        req_valid[i] = v; req_we[i] = we; req_lock[i] = lk;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b0, 1'b0, 16'(i), 32'h0);
        tick();
        chk_en = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #2;
            n_vec++;
            if (req_ready !== 4'b0000 || mem_we !== 1'b0 || mem_addr !== 16'h0 ||
                rsp_valid !== 4'b0000 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state ready=%b we=%b addr=%h rsp=%b busy=%b exp all zero",
                         req_ready, mem_we, mem_addr, rsp_valid, busy);
            end
            tick();
        end
        reset = 1'b0;
        #2;
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_first_grant got=%b exp=0001", req_ready);
        end
        tick();
        idle_all();
        tick(); tick();
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        reset = 1'b1; idle_all(); tick(); reset = 1'b0;
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b0, 1'b0, 16'(10 + i), 32'h0);
        for (int k = 0; k < 7; k++) begin
            if (k == 5) idle_all();
            #2;
            if (k < 5) begin
                n_vec++;
                if (req_ready !== (4'b0001 << order[k])) begin
                    n_err++;
                    $display("FAIL rr_grant beat=%0d got=%b exp core %0d", k, req_ready, order[k]);
                end
            end
            if (k >= 2) begin
                n_vec++;
                if (rsp_valid !== (4'b0001 << order[k-2]) || rsp_data !== pat(16'(10 + order[k-2]))) begin
                    n_err++;
                    $display("FAIL rr_rsp beat=%0d got v=%b d=%h exp core %0d d=%h", k - 2,
                             rsp_valid, rsp_data, order[k-2], pat(16'(10 + order[k-2])));
                end
            end
            tick();
        end
        tick();
    endtask

    task automatic test_locked_burst();
        idle_all();
        set_core(1, 1'b1, 1'b0, 1'b0, 16'd100, 32'h0);
        tick();
        set_core(0, 1'b1, 1'b0, 1'b0, 16'd200, 32'h0);
        set_core(1, 1'b1, 1'b0, 1'b0, 16'd201, 32'h0);
        for (int k = 0; k < 16; k++) begin
            set_core(2, 1'b1, 1'b0, (k < 15), 16'(k), 32'h0);
            #2;
            n_vec++;
            if (req_ready !== 4'b0100) begin
                n_err++;
                $display("FAIL burst_grant beat=%0d got=%b exp=0100", k, req_ready);
            end
            if (k > 0) begin
                n_vec++;
                if (busy !== 1'b1 || owner !== 2'd2) begin
                    n_err++;
                    $display("FAIL burst_owner beat=%0d got busy=%b owner=%0d exp busy=1 owner=2", k, busy, owner);
                end
            end
            tick();
        end
        req_valid[2] = 1'b0;
        #2;
        n_vec++;
        if (req_ready !== 4'b0001 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL burst_after got ready=%b busy=%b exp ready=0001 busy=0", req_ready, busy);
        end
        tick();
        idle_all();
        tick(); tick(); tick();
    endtask

    task automatic test_forced_release();
        int gexp [6] = '{1, 1, 1, 1, 0, 1};
        bit bexp [6] = '{0, 1, 1, 1, 0, 0};
        logic [15:0] ea;
        logic [31:0] ed;
        reset = 1'b1; idle_all(); tick(); reset = 1'b0;
        b_req_we = 4'b0011;
        b_req_lock = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            b_req_valid = (k == 0) ? 4'b0010 : 4'b0011;
            b_req_addr[0*AW +: AW] = 16'(16'h80 + k);
            b_req_addr[1*AW +: AW] = 16'(16'h40 + k);
            b_req_wdata[0*DW +: DW] = 32'h2000_0000 + k;
            b_req_wdata[1*DW +: DW] = 32'h1000_0000 + k;
            #2;
            n_vec++;
            if (b_req_ready !== (4'b0001 << gexp[k]) || b_busy !== bexp[k]) begin
                n_err++;
                $display("FAIL forced_grant beat=%0d got ready=%b busy=%b exp core %0d busy=%b",
                         k, b_req_ready, b_busy, gexp[k], bexp[k]);
            end
            if (bexp[k]) begin
                n_vec++;
                if (b_owner !== 2'd1) begin
                    n_err++;
                    $display("FAIL forced_owner beat=%0d got=%0d exp=1", k, b_owner);
                end
            end
            tick();
            ea = (gexp[k] == 1) ? 16'(16'h40 + k) : 16'(16'h80 + k);
            ed = (gexp[k] == 1) ? 32'h1000_0000 + k : 32'h2000_0000 + k;
            n_vec++;
            if (b_mem_we !== 1'b1 || b_mem_addr !== ea || b_mem_write_data !== ed) begin
                n_err++;
                $display("FAIL forced_memport beat=%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h",
                         k, b_mem_we, b_mem_addr, b_mem_write_data, ea, ed);
            end
        end
        b_req_valid = '0; b_req_lock = '0;
        tick();
        n_vec++;
        if (b_mem_we !== 1'b0 || b_rsp_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL forced_quiet got we=%b rsp=%b exp 0", b_mem_we, b_rsp_valid);
        end
    endtask

    task automatic test_write_then_read();
        idle_all();
        set_core(3, 1'b1, 1'b1, 1'b0, 16'h0020, 32'hDEADBEEF);
        #2;
        n_vec++;
        if (req_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL wtr_grant_w got=%b exp=1000", req_ready);
        end
        tick();
        n_vec++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_write_data !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL wtr_write got we=%b a=%h d=%h exp we=1 a=0020 d=deadbeef", mem_we, mem_addr, mem_write_data);
        end
        set_core(3, 1'b1, 1'b0, 1'b0, 16'h0020, 32'h0);
        tick();
        n_vec++;
        if (mem_we !== 1'b0 || mem_addr !== 16'h0020) begin
            n_err++;
            $display("FAIL wtr_pulse got we=%b a=%h exp we=0 a=0020", mem_we, mem_addr);
        end
        idle_all();
        tick();
        n_vec++;
        if (rsp_valid !== 4'b1000 || rsp_data !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL wtr_read got v=%b d=%h exp v=1000 d=deadbeef", rsp_valid, rsp_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        idle_all();
        set_core(1, 1'b1, 1'b0, 1'b1, 16'h0055, 32'h0);
        #2;
        n_vec++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL midrst_grant got=%b exp=0010", req_ready);
        end
        tick();
        reset = 1'b1;
        #2;
        n_vec++;
        if (req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL midrst_ready got=%b exp=0000", req_ready);
        end
        tick();
        n_vec++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_drop got rsp=%b busy=%b exp rsp=0000 busy=0", rsp_valid, busy);
        end
        reset = 1'b0;
        set_core(0, 1'b1, 1'b0, 1'b0, 16'h0056, 32'h0);
        #2;
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL midrst_unlock got=%b exp=0001", req_ready);
        end
        tick();
        idle_all();
        tick(); tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom % 64) == 0;
            for (int i = 0; i < N; i++) begin
                set_core(i, ($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 4) == 0,
                         16'($urandom % 32), $urandom);
            end
            #2;
            n_vec++;
            if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != 4'b0000) begin
                n_err++;
                $display("FAIL rand_onehot cyc=%0d got ready=%b valid=%b", cyc, req_ready, req_valid);
            end
            tick();
        end
        reset = 1'b0;
        idle_all();
        tick(); tick(); tick();
    endtask

    initial begin
        n_vec = 0; n_err = 0; chk_en = 1'b0; cyc = 0;
        m_rr = 0; m_own = 0; m_owner = 0; m_cnt = 0;
        m_we = 1'b0; m_addr = '0; m_wdata = '0;
        for (int i = 0; i < 8; i++) begin
            exp_core[i] = -1;
            exp_data[i] = '0;
        end
        reset = 1'b1;
        req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        b_req_valid = '0; b_req_we = '0; b_req_lock = '0; b_req_addr = '0; b_req_wdata = '0;
        fork
            model_loop();
            scoreboard_loop();
        join_none
        test_reset();
        test_round_robin();
        test_locked_burst();
        test_forced_release();
        test_write_then_read();
        test_reset_mid_burst();
        test_random();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
